// File: rtl/ras_ctrl_if.sv
// Requester-side handshake bundle for ras_ctrl: two requesters (0 = predict, 1 = replay)
// share one set of valid/push/pop/data lanes and receive per-requester grants.
interface ras_ctrl_if #(
   parameter int WIDTH = 32
);
   logic [1:0]         req_valid;
   logic [1:0]         req_push;
   logic [1:0]         req_pop;
   logic [2*WIDTH-1:0] req_data;
   logic [1:0]         req_ready;

   modport master (output req_valid, req_push, req_pop, req_data, input req_ready);
   modport slave  (input req_valid, req_push, req_pop, req_data, output req_ready);
endinterface

// File: rtl/ras_ctrl.sv
// Speculative return-address-stack sequencer: round-robin push/pop arbitration, per-level
// occupancy tracking, registered commit/flush pulses. Define RAS_CTRL_STATS_EN for statistics counters.
module ras_ctrl #(
   parameter  int STAGES       = 2,
   parameter  int WIDTH        = 32,
   parameter  int MAX_BRANCHES = 16,
   localparam int CW           = $clog2(MAX_BRANCHES + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   ras_ctrl_if.slave            req,
   input  logic [STAGES-1:0]    adv,
   output logic [STAGES-1:0]    adv_ready,
   input  logic [STAGES-1:0]    kill,
   output logic                 ras_push,
   output logic                 ras_pop,
   output logic [WIDTH-1:0]     ras_din,
   output logic [STAGES-1:0]    ras_commit,
   output logic [STAGES-1:0]    ras_flush,
   output logic [STAGES*CW-1:0] occ,
   output logic                 err,
   output logic [31:0]          stat_ops,
   output logic [31:0]          stat_flush,
   output logic [31:0]          stat_stall
);
   logic                ptr_q;
   logic [CW-1:0]       occ_q   [STAGES];
   logic [CW-1:0]       occ_nxt [STAGES];
   logic                kill_any, blocked, accept, gsel, g_push, g_pop, active;
   logic [1:0]          gnt;
   logic [WIDTH-1:0]    g_data;
   logic [STAGES-1:0]   ar, adv_acc, flush_mask, occ_inc, adv_err;
   logic                ras_push_p1, ras_pop_p1;
   logic [WIDTH-1:0]    ras_din_p1;
   logic [STAGES-1:0]   ras_commit_p1, ras_flush_p1;
   logic                err_q;

   // Stage p0: arbitration, advance acceptance and next occupancy (combinational)
   always_comb begin
      kill_any = |kill;
      blocked  = kill_any || (occ_q[0] == CW'(MAX_BRANCHES)) || reset;
      gnt      = '0;
      if (!blocked) begin
         if (req.req_valid[ptr_q])       gnt[ptr_q]  = 1'b1;
         else if (req.req_valid[!ptr_q]) gnt[!ptr_q] = 1'b1;
      end
      accept = |gnt;
      gsel   = gnt[1];
      g_push = req.req_push[gsel];
      g_pop  = req.req_pop[gsel];
      g_data = gsel ? req.req_data[2*WIDTH-1:WIDTH] : req.req_data[WIDTH-1:0];
      active = accept && (g_push || g_pop);

      // A level may drain into a full level above only if that level drains this same cycle.
      ar = '0;
      ar[STAGES-1] = (occ_q[STAGES-1] != '0) && !kill_any;
      for (int i = STAGES-2; i >= 0; i--)
         ar[i] = (occ_q[i] != '0) && !kill_any &&
                 ((occ_q[i+1] != CW'(MAX_BRANCHES)) || (adv[i+1] && ar[i+1]));
      adv_acc = adv & ar;

      adv_err = '0;
      for (int i = 0; i < STAGES; i++) begin
         adv_err[i]    = adv[i] && (occ_q[i] == '0);
         flush_mask[i] = |(kill >> i);
      end

      occ_inc = STAGES'({adv_acc, active});
      for (int i = 0; i < STAGES; i++)
         occ_nxt[i] = flush_mask[i] ? '0 : occ_q[i] + CW'(occ_inc[i]) - CW'(adv_acc[i]);
   end

   assign req.req_ready = gnt;
   assign adv_ready     = ar;

   // Stage p1: registered stack-facing outputs and control state
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q         <= 1'b0;
         ras_push_p1   <= 1'b0;
         ras_pop_p1    <= 1'b0;
         ras_din_p1    <= '0;
         ras_commit_p1 <= '0;
         ras_flush_p1  <= '0;
         err_q         <= 1'b0;
         for (int i = 0; i < STAGES; i++) occ_q[i] <= '0;
      end else begin
         if (accept) ptr_q <= !gsel;
         ras_push_p1   <= active && g_push;
         ras_pop_p1    <= active && g_pop;
         if (active && g_push) ras_din_p1 <= g_data;
         ras_commit_p1 <= adv_acc;
         ras_flush_p1  <= flush_mask;
         err_q         <= err_q || (|adv_err);
         for (int i = 0; i < STAGES; i++) occ_q[i] <= occ_nxt[i];
      end
   end

   always_comb begin
      occ = '0;
      for (int i = 0; i < STAGES; i++) occ[i*CW +: CW] = occ_q[i];
   end

   assign ras_push   = ras_push_p1;
   assign ras_pop    = ras_pop_p1;
   assign ras_din    = ras_din_p1;
   assign ras_commit = ras_commit_p1;
   assign ras_flush  = ras_flush_p1;
   assign err        = err_q;

`ifdef RAS_CTRL_STATS_EN
   logic [31:0] stat_ops_q, stat_flush_q, stat_stall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stat_ops_q   <= '0;
         stat_flush_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_ops_q   <= stat_ops_q + 32'(active);
         stat_flush_q <= stat_flush_q + 32'(kill_any);
         stat_stall_q <= stat_stall_q + 32'((|req.req_valid) && !accept);
      end
   end

   assign stat_ops   = stat_ops_q;
   assign stat_flush = stat_flush_q;
   assign stat_stall = stat_stall_q;
`else
   assign stat_ops   = '0;
   assign stat_flush = '0;
   assign stat_stall = '0;
`endif
endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl (STAGES=2, MAX_BRANCHES=4) with hand-computed expectations.
module tb_ras_ctrl;
   localparam int STAGES = 2;
   localparam int WIDTH  = 32;
   localparam int MAXB   = 4;
   localparam int CW     = 3;

   logic clk = 1'b0;
   logic reset;
   logic [STAGES-1:0]    adv, adv_ready, kill, ras_commit, ras_flush;
   logic                 ras_push, ras_pop, err;
   logic [WIDTH-1:0]     ras_din;
   logic [STAGES*CW-1:0] occ;
   logic [31:0]          stat_ops, stat_flush, stat_stall;
   int passed = 0;
   int total  = 0;

   ras_ctrl_if #(.WIDTH(WIDTH)) rif ();

   ras_ctrl #(.STAGES(STAGES), .WIDTH(WIDTH), .MAX_BRANCHES(MAXB)) dut (
      .clk(clk), .reset(reset), .req(rif),
      .adv(adv), .adv_ready(adv_ready), .kill(kill),
      .ras_push(ras_push), .ras_pop(ras_pop), .ras_din(ras_din),
      .ras_commit(ras_commit), .ras_flush(ras_flush), .occ(occ), .err(err),
      .stat_ops(stat_ops), .stat_flush(stat_flush), .stat_stall(stat_stall)
   );

   always #5 clk = ~clk;

   function automatic logic [CW-1:0] occ_at(input int i);
      return occ[i*CW +: CW];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      rif.req_valid = '0;
      rif.req_push  = '0;
      rif.req_pop   = '0;
      rif.req_data  = '0;
      adv  = '0;
      kill = '0;
   endtask

   task automatic do_reset;
      idle();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      idle();
      reset = 1'b1;
      rif.req_valid = 2'b11;
      rif.req_push  = 2'b11;
      #1;
      total++; if (rif.req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", rif.req_ready); else passed++;
      tick();
      total++;
      if ({ras_push, ras_pop, ras_din, ras_commit, ras_flush, occ, err} !== '0)
         $display("FAIL reset_outputs: push=%b pop=%b din=%h commit=%b flush=%b occ=%h err=%b want all 0",
                  ras_push, ras_pop, ras_din, ras_commit, ras_flush, occ, err);
      else passed++;
      total++;
      if ({stat_ops, stat_flush, stat_stall} !== '0)
         $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", stat_ops, stat_flush, stat_stall);
      else passed++;
      reset = 1'b0;
      idle();
   endtask

   task automatic test_arbitration;
      logic [1:0]  exp_gnt;
      logic [31:0] exp_din;
      do_reset();
      rif.req_valid = 2'b11;
      rif.req_push  = 2'b11;
      rif.req_data  = {32'h200, 32'h100};
      for (int c = 0; c < 4; c++) begin
         exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
         exp_din = (c % 2 == 0) ? 32'h100 : 32'h200;
         #1;
         total++; if (rif.req_ready !== exp_gnt) $display("FAIL arb_grant%0d: got %b want %b", c, rif.req_ready, exp_gnt); else passed++;
         tick();
         total++; if (ras_push !== 1'b1 || ras_din !== exp_din) $display("FAIL arb_din%0d: push=%b din=%h want 1 %h", c, ras_push, ras_din, exp_din); else passed++;
         total++; if (occ_at(0) !== CW'(c + 1)) $display("FAIL arb_occ%0d: got %0d want %0d", c, occ_at(0), c + 1); else passed++;
      end
      idle();
   endtask

   task automatic test_fill_drain;
      do_reset();
      rif.req_valid = 2'b01;
      rif.req_push  = 2'b01;
      rif.req_data  = {32'h0, 32'h55};
      for (int c = 0; c < 4; c++) begin
         #1;
         total++; if (rif.req_ready !== 2'b01) $display("FAIL fill_grant%0d: got %b want 01", c, rif.req_ready); else passed++;
         tick();
      end
      #1;
      total++; if (rif.req_ready !== 2'b00) $display("FAIL fill_stall_ready: got %b want 00", rif.req_ready); else passed++;
      tick();
      total++; if (occ_at(0) !== CW'(4)) $display("FAIL fill_occ_full: got %0d want 4", occ_at(0)); else passed++;
`ifdef RAS_CTRL_STATS_EN
      total++; if (stat_stall !== 32'd1) $display("FAIL fill_stat_stall: got %0d want 1", stat_stall); else passed++;
`else
      total++; if (stat_stall !== 32'd0) $display("FAIL fill_stat_stall: got %0d want 0", stat_stall); else passed++;
`endif
      adv = 2'b01;
      #1;
      total++; if (rif.req_ready !== 2'b00 || adv_ready !== 2'b01) $display("FAIL fill_adv_cycle: ready=%b adv_ready=%b want 00 01", rif.req_ready, adv_ready); else passed++;
      tick();
      adv = 2'b00;
      total++; if (ras_commit !== 2'b01 || occ_at(0) !== CW'(3) || occ_at(1) !== CW'(1)) $display("FAIL fill_adv: commit=%b occ=(%0d,%0d) want 01 (3,1)", ras_commit, occ_at(0), occ_at(1)); else passed++;
      #1;
      total++; if (rif.req_ready !== 2'b01) $display("FAIL fill_resume: got %b want 01", rif.req_ready); else passed++;
      tick();
      total++; if (ras_push !== 1'b1 || occ_at(0) !== CW'(4)) $display("FAIL fill_resume_push: push=%b occ0=%0d want 1 4", ras_push, occ_at(0)); else passed++;
      idle();
   endtask

   task automatic test_advance_chain;
      do_reset();
      rif.req_valid = 2'b01;
      rif.req_push  = 2'b01;
      tick();
      tick();
      idle();
      total++; if (occ_at(0) !== CW'(2) || occ_at(1) !== CW'(0)) $display("FAIL chain_occ_a: got (%0d,%0d) want (2,0)", occ_at(0), occ_at(1)); else passed++;
      adv = 2'b01;
      #1;
      total++; if (adv_ready !== 2'b01) $display("FAIL chain_ready_a: got %b want 01", adv_ready); else passed++;
      tick();
      total++; if (ras_commit !== 2'b01 || occ_at(0) !== CW'(1) || occ_at(1) !== CW'(1)) $display("FAIL chain_b: commit=%b occ=(%0d,%0d) want 01 (1,1)", ras_commit, occ_at(0), occ_at(1)); else passed++;
      adv = 2'b10;
      #1;
      total++; if (adv_ready !== 2'b11) $display("FAIL chain_ready_b: got %b want 11", adv_ready); else passed++;
      tick();
      total++; if (ras_commit !== 2'b10 || occ_at(0) !== CW'(1) || occ_at(1) !== CW'(0)) $display("FAIL chain_c: commit=%b occ=(%0d,%0d) want 10 (1,0)", ras_commit, occ_at(0), occ_at(1)); else passed++;
      adv = 2'b00;
      tick();
      total++; if (ras_commit !== 2'b00) $display("FAIL chain_pulse: got %b want 00", ras_commit); else passed++;
   endtask

   task automatic test_kill;
      do_reset();
      rif.req_valid = 2'b01;
      rif.req_push  = 2'b01;
      tick();
      tick();
      idle();
      adv = 2'b01;
      tick();
      tick();
      adv = 2'b00;
      rif.req_valid = 2'b01;
      rif.req_push  = 2'b01;
      for (int c = 0; c < 3; c++) tick();
      idle();
      total++; if (occ_at(0) !== CW'(3) || occ_at(1) !== CW'(2)) $display("FAIL kill_setup: got (%0d,%0d) want (3,2)", occ_at(0), occ_at(1)); else passed++;
      rif.req_valid = 2'b01;
      rif.req_push  = 2'b01;
      rif.req_data  = {32'h0, 32'hABC};
      kill = 2'b01;
      #1;
      total++; if (rif.req_ready !== 2'b00) $display("FAIL kill_block: got %b want 00", rif.req_ready); else passed++;
      tick();
      kill = 2'b00;
      total++; if (ras_flush !== 2'b01 || ras_commit !== 2'b00 || ras_push !== 1'b0) $display("FAIL kill_flush_a: flush=%b commit=%b push=%b want 01 00 0", ras_flush, ras_commit, ras_push); else passed++;
      total++; if (occ_at(0) !== CW'(0) || occ_at(1) !== CW'(2)) $display("FAIL kill_occ_a: got (%0d,%0d) want (0,2)", occ_at(0), occ_at(1)); else passed++;
      #1;
      total++; if (rif.req_ready !== 2'b01) $display("FAIL kill_regrant: got %b want 01", rif.req_ready); else passed++;
      tick();
      idle();
      total++; if (ras_push !== 1'b1 || ras_din !== 32'hABC || ras_flush !== 2'b00) $display("FAIL kill_push: push=%b din=%h flush=%b want 1 abc 00", ras_push, ras_din, ras_flush); else passed++;
      kill = 2'b10;
      adv  = 2'b10;
      #1;
      total++; if (adv_ready !== 2'b00) $display("FAIL kill_adv_block: got %b want 00", adv_ready); else passed++;
      tick();
      idle();
      total++; if (ras_flush !== 2'b11 || ras_commit !== 2'b00 || occ !== '0) $display("FAIL kill_flush_b: flush=%b commit=%b occ=%h want 11 00 0", ras_flush, ras_commit, occ); else passed++;
`ifdef RAS_CTRL_STATS_EN
      total++; if (stat_flush !== 32'd2) $display("FAIL kill_stat_flush: got %0d want 2", stat_flush); else passed++;
`endif
   endtask

   task automatic test_error_reset;
      do_reset();
      adv = 2'b10;
      #1;
      total++; if (adv_ready !== 2'b00) $display("FAIL err_adv_ready: got %b want 00", adv_ready); else passed++;
      tick();
      adv = 2'b00;
      total++; if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else passed++;
      rif.req_valid = 2'b01;
      rif.req_push  = 2'b01;
      rif.req_data  = {32'h0, 32'h77};
      tick();
      total++; if (err !== 1'b1 || ras_push !== 1'b1) $display("FAIL err_sticky: err=%b push=%b want 1 1", err, ras_push); else passed++;
      reset = 1'b1;
      rif.req_valid = 2'b11;
      rif.req_push  = 2'b11;
      #1;
      total++; if (rif.req_ready !== 2'b00) $display("FAIL mid_reset_ready: got %b want 00", rif.req_ready); else passed++;
      tick();
      reset = 1'b0;
      total++;
      if ({ras_push, ras_pop, ras_din, ras_commit, ras_flush, occ, err} !== '0)
         $display("FAIL mid_reset_outputs: push=%b din=%h occ=%h err=%b want all 0", ras_push, ras_din, occ, err);
      else passed++;
      #1;
      total++; if (rif.req_ready !== 2'b01) $display("FAIL mid_reset_ptr: got %b want 01", rif.req_ready); else passed++;
      idle();
      tick();
   endtask

   initial begin
      idle();
      reset = 1'b1;
      test_reset();
      test_arbitration();
      test_fill_drain();
      test_advance_chain();
      test_kill();
      test_error_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion want finish within 200000 time units");
      $fatal(1, "timeout");
   end
endmodule
